fp16_add: RTL and testbench
===========================

Name: fp16_add

Overview:
- Registered IEEE-754 binary16 (half-precision) adder: two 16-bit operands in, one 16-bit sum out.
- Sits in the FP datapath as a single-stage arithmetic unit.
- Truncating, flush-to-zero, saturate-to-infinity semantics.
- Combinational add core followed by one output register.

Parameters:
- None. Format is fixed: 1 sign bit, 5 exponent bits (bias 15), 10 fraction bits.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTn  input  1  asynchronous active-low reset.
- OP1_i  input  16  operand 1, binary16.
- OP2_i  input  16  operand 2, binary16.
- ADD_o  output  16  registered sum, binary16.

Behaviour:
- Reset: while RSTn=0, ADD_o=16'h0000, applied immediately regardless of CLK. First capture is on the first rising CLK edge after RSTn rises.
- Latency: 1 cycle. ADD_o on each rising edge = f(OP1_i, OP2_i) sampled at that edge. No handshake; a new result is produced every cycle.
- Operand classes: exp=0 is treated as zero; subnormal inputs are also treated as zero (DAZ). exp=31 with frac=0 is ±inf. exp=31 with frac≠0 is NaN.
- Special precedence:
  - Any NaN, or +inf plus -inf → 16'h7E00.
  - Otherwise, any inf → inf with that sign.
  - Otherwise, if one operand is zero → the other operand unchanged.
  - Both zero → 16'h0000.
- Significands: 11 bits, with the hidden 1 prepended.
- Alignment:
  - The operand with the larger magnitude (compare exp, then frac) is the big operand.
  - Right-shift the small operand's significand by the exponent difference. Shifted-out bits are DISCARDED (no guard/round/sticky).
  - A difference ≥11 makes the small significand 0.
- Same signs: add to a 12-bit sum.
  - If bit 11 is set: shift right 1 (drop LSB) and exp+1.
  - Result sign = common sign.
- Different signs: big minus small.
  - A zero difference gives 16'h0000.
  - Otherwise, left-normalize by the leading-zero count and subtract that count from exp.
  - Result sign = big operand's sign.
- Overflow: result exp ≥31 → ±inf (sign kept): 16'h7C00 or 16'hFC00.
- Underflow: result exp ≤0 → 16'h0000, always +0, even for negative results.
- Rounding: truncation (toward zero of the aligned sum), per the alignment rule above.
- Exact cancellation always yields +0.
- Inputs may change every cycle; there is no internal state besides the output register.

Optional Feature:
- Macro: FP16_ADD_RNE_EN.
- Defined:
  - Alignment keeps guard, round and sticky bits.
  - The normalized result is rounded to nearest, ties-to-even.
  - A rounding carry renormalizes, and may overflow to inf.
  - Underflow and special-value rules are unchanged.
- Undefined: truncating behaviour exactly as specified in Behaviour.
- All Test Plan values below assume the macro is undefined.

Test Plan:
- Reset and same-sign add:
  - Assert RSTn=0 mid-run → ADD_o=0000 immediately.
  - Release reset, then 5300+5300 → 5700 after one edge.
  - 4800+5800 → 5840.
- Overflow:
  - 7800+7800 → 7C00.
  - 7BFF+5000 → 7C00.
  - F800+F800 → FC00.
- Truncating subtract:
  - 53FF+C3FF → 5380 (not 537F).
  - 5400+CFFF → 5002.
  - 4000+D001 → CF82.
  - 4C01+C800 → 4802.
- Cancellation and flush:
  - 47FF+C7FF → 0000.
  - 0800+87FF → 0000.
  - 0400+8401 → 0000 (positive zero).
- Specials:
  - 7C00+FC00 → 7E00.
  - 7C00+4000 → 7C00.
  - 0000+1021 → 1021.
  - 0000+0000 → 0000.
  - 0001+3C00 → 3C00 (subnormal input treated as zero).
- Throughput: change operands every cycle across 10 random pairs → each ADD_o matches the truncating reference model, delayed exactly one cycle.

Source files
------------

// File: rtl/fp16_add.sv
// fp16_add: registered binary16 adder with truncation, DAZ/FTZ and saturation to infinity.
// Define FP16_ADD_RNE_EN to keep guard/round/sticky bits and round to nearest, ties-to-even.
module fp16_add (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [15:0] OP1_i,
  input  logic [15:0] OP2_i,
  output logic [15:0] ADD_o
);

`ifdef FP16_ADD_RNE_EN
  localparam int XB = 3;
`else
  localparam int XB = 0;
`endif
  localparam int MW = 11 + XB;

  logic [15:0]       add_d, add_q;
  logic [15:0]       opBig, opSml;
  logic [4:0]        expDiff;
  logic [MW-1:0]     sigBig, sigSml, diffVal, mant;
  logic [MW:0]       sumWide;
  logic [3:0]        lzc;
  logic signed [6:0] expRes, expRnd;
  logic [9:0]        fracRes;
  logic              nan1, nan2, inf1, inf2, zero1, zero2;

  assign nan1  = (&OP1_i[14:10]) & (|OP1_i[9:0]);
  assign nan2  = (&OP2_i[14:10]) & (|OP2_i[9:0]);
  assign inf1  = (&OP1_i[14:10]) & ~(|OP1_i[9:0]);
  assign inf2  = (&OP2_i[14:10]) & ~(|OP2_i[9:0]);
  assign zero1 = ~(|OP1_i[14:10]);
  assign zero2 = ~(|OP2_i[14:10]);

  always_comb begin
    if (OP1_i[14:0] >= OP2_i[14:0]) begin
      opBig = OP1_i;
      opSml = OP2_i;
    end else begin
      opBig = OP2_i;
      opSml = OP1_i;
    end
    expDiff = opBig[14:10] - opSml[14:10];
    sigBig  = MW'({1'b1, opBig[9:0]}) << XB;
  end

`ifdef FP16_ADD_RNE_EN
  logic [34:0] wideSml;
  // Everything shifted past the round bit collapses into the sticky LSB.
  always_comb begin
    wideSml = {1'b1, opSml[9:0], 24'd0} >> expDiff;
    sigSml  = {wideSml[34:22], |wideSml[21:0]};
  end
`else
  assign sigSml = (MW'({1'b1, opSml[9:0]}) << XB) >> expDiff;
`endif

  always_comb begin
    sumWide = {1'b0, sigBig} + {1'b0, sigSml};
    diffVal = sigBig - sigSml;
    lzc     = '0;
    for (int i = 0; i < MW; i++)
      if (diffVal[i]) lzc = 4'(MW - 1 - i);
    if (opBig[15] == opSml[15]) begin
      if (sumWide[MW]) begin
        mant = sumWide[MW:1];
`ifdef FP16_ADD_RNE_EN
        mant[0] = sumWide[1] | sumWide[0];
`endif
        expRes = $signed({2'b00, opBig[14:10]}) + 7'sd1;
      end else begin
        mant   = sumWide[MW-1:0];
        expRes = $signed({2'b00, opBig[14:10]});
      end
    end else begin
      mant   = diffVal << lzc;
      expRes = $signed({2'b00, opBig[14:10]}) - $signed({3'b000, lzc});
    end
  end

`ifdef FP16_ADD_RNE_EN
  logic        roundUp;
  logic [11:0] rounded;
  always_comb begin
    roundUp = mant[2] & (mant[3] | mant[1] | mant[0]);
    rounded = {1'b0, mant[13:3]} + {11'd0, roundUp};
    if (rounded[11]) begin
      fracRes = rounded[10:1];
      expRnd  = expRes + 7'sd1;
    end else begin
      fracRes = rounded[9:0];
      expRnd  = expRes;
    end
  end
`else
  assign fracRes = mant[9:0];
  assign expRnd  = expRes;
`endif

  // A cleared hidden bit after normalisation means exact cancellation.
  always_comb begin
    add_d = 16'h0000;
    if (nan1 || nan2 || (inf1 && inf2 && (OP1_i[15] != OP2_i[15])))
      add_d = 16'h7E00;
    else if (inf1)
      add_d = {OP1_i[15], 15'h7C00};
    else if (inf2)
      add_d = {OP2_i[15], 15'h7C00};
    else if (zero1)
      add_d = zero2 ? 16'h0000 : OP2_i;
    else if (zero2)
      add_d = OP1_i;
    else if (!mant[MW-1])
      add_d = 16'h0000;
    else if (expRnd >= 7'sd31)
      add_d = {opBig[15], 15'h7C00};
    else if (expRnd <= 7'sd0)
      add_d = 16'h0000;
    else
      add_d = {opBig[15], expRnd[4:0], fracRes};
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) add_q <= 16'h0000;
    else       add_q <= add_d;
  end

  assign ADD_o = add_q;

endmodule

// File: tb/tb_fp16_add.sv
// tb_fp16_add: directed and random checks of fp16_add against an integer-arithmetic reference.
module tb_fp16_add;

  logic        CLK;
  logic        RSTn;
  logic [15:0] OP1_i, OP2_i;
  logic [15:0] ADD_o;
  int          errors = 0;
  int          checks = 0;

  fp16_add dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .OP1_i(OP1_i),
    .OP2_i(OP2_i),
    .ADD_o(ADD_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: treat significands as integers, align with floor division, renormalise by loops.
  function automatic logic [15:0] refAdd(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, fa, fb, magA, magB, eBig, sigB, sigS, d, r, e;
    logic sa, sb, sBig, sSml;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    sa = a[15];          sb = b[15];
    if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0)) return 16'h7E00;
    if (ea == 31 && eb == 31 && sa != sb) return 16'h7E00;
    if (ea == 31) return a;
    if (eb == 31) return b;
    if (ea == 0 && eb == 0) return 16'h0000;
    if (ea == 0) return b;
    if (eb == 0) return a;
    magA = int'(a[14:0]); magB = int'(b[14:0]);
    if (magA >= magB) begin
      eBig = ea; sigB = 1024 + fa; sBig = sa; sSml = sb; d = ea - eb; sigS = 1024 + fb;
    end else begin
      eBig = eb; sigB = 1024 + fb; sBig = sb; sSml = sa; d = eb - ea; sigS = 1024 + fa;
    end
    sigS = (d >= 11) ? 0 : sigS / (1 << d);
    r = (sBig == sSml) ? sigB + sigS : sigB - sigS;
    if (r == 0) return 16'h0000;
    e = eBig;
    while (r >= 2048) begin r = r / 2; e++; end
    while (r < 1024)  begin r = r * 2; e--; end
    if (e >= 31) return {sBig, 15'h7C00};
    if (e <= 0)  return 16'h0000;
    return {sBig, 5'(e), 10'(r - 1024)};
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    @(negedge CLK);
    OP1_i = a;
    OP2_i = b;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] expected);
    checks++;
    assert (ADD_o === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: ADD_o=%h expected=%h", tag, ADD_o, expected);
      end
  endtask

  task automatic addAndCheck(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] expected);
    applyStimulus(a, b);
    @(posedge CLK);
    #1;
    checkOutput(tag, expected);
  endtask

  initial begin
    logic [15:0] ra, rb, prevExp, curExp;
    RSTn  = 1'b0;
    OP1_i = 16'h0000;
    OP2_i = 16'h0000;
    #12;
    checkOutput("reset_initial", 16'h0000);
    @(negedge CLK);
    RSTn = 1'b1;

    addAndCheck("same_5300", 16'h5300, 16'h5300, 16'h5700);
    addAndCheck("same_4800", 16'h4800, 16'h5800, 16'h5840);

    // Reset asserted away from any clock edge must clear the output at once.
    #2;
    RSTn = 1'b0;
    #1;
    checkOutput("reset_midrun", 16'h0000);
    @(negedge CLK);
    RSTn = 1'b1;
    #1;
    checkOutput("reset_held", 16'h0000);

    addAndCheck("ovf_7800",   16'h7800, 16'h7800, 16'h7C00);
    addAndCheck("ovf_7BFF",   16'h7BFF, 16'h5000, 16'h7C00);
    addAndCheck("ovf_neg",    16'hF800, 16'hF800, 16'hFC00);
    addAndCheck("sub_53FF",   16'h53FF, 16'hC3FF, 16'h5380);
    addAndCheck("sub_5400",   16'h5400, 16'hCFFF, 16'h5002);
    addAndCheck("sub_4000",   16'h4000, 16'hD001, 16'hCF82);
    addAndCheck("sub_4C01",   16'h4C01, 16'hC800, 16'h4802);
    addAndCheck("cancel",     16'h47FF, 16'hC7FF, 16'h0000);
    addAndCheck("flush_0800", 16'h0800, 16'h87FF, 16'h0000);
    addAndCheck("flush_pos0", 16'h0400, 16'h8401, 16'h0000);
    addAndCheck("inf_minus",  16'h7C00, 16'hFC00, 16'h7E00);
    addAndCheck("inf_plus",   16'h7C00, 16'h4000, 16'h7C00);
    addAndCheck("zero_op",    16'h0000, 16'h1021, 16'h1021);
    addAndCheck("zero_zero",  16'h0000, 16'h0000, 16'h0000);
    addAndCheck("daz",        16'h0001, 16'h3C00, 16'h3C00);
    addAndCheck("nan_in",     16'h7C01, 16'h3C00, 16'h7E00);

    // Back-to-back random pairs: the output must hold until the edge, then show the new sum.
    prevExp = refAdd(16'h0001, 16'h3C00);
    prevExp = refAdd(OP1_i, OP2_i);
    for (int k = 0; k < 10; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 2 == 0) begin
        ra[14:13] = 2'b01;
        rb[14:13] = 2'b01;
      end
      curExp = refAdd(ra, rb);
      applyStimulus(ra, rb);
      #1;
      checkOutput($sformatf("hold_%0d", k), prevExp);
      @(posedge CLK);
      #1;
      checkOutput($sformatf("rand_%0d_%h_%h", k, ra, rb), curExp);
      prevExp = curExp;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
